// File: rtl/pll_seq_pkg.sv
// Shared state type and counter-sizing helpers for the PLL reset/lock sequencer.
package pll_seq_pkg;

   typedef enum logic [2:0] {
      PLL_RST   = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RELEASE   = 3'd3,
      RUN       = 3'd4,
      FAIL      = 3'd5
   } pll_seq_state_t;

   // Bits needed for a counter that must be able to hold max_val itself.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; clears to 0 under reset.
module sync_2ff (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Pulses the PLL reset, waits for a debounced lock, then releases the clock-domain
// resets one by one; retries on lock timeout and collapses everything on lock loss.
module pll_reset_sequencer
   import pll_seq_pkg::*;
#(
   parameter int unsigned RST_CYCLES   = 16,
   parameter int unsigned LOCK_STABLE  = 1024,
   parameter int unsigned LOCK_TIMEOUT = 65536,
   parameter int unsigned STAGE_GAP    = 8,
   parameter int unsigned NUM_DOMAINS  = 4,
   parameter int unsigned MAX_RETRIES  = 3
) (
   input  logic                             refclk,
   input  logic                             rst_n,
   input  logic                             pll_locked,
   input  logic                             restart,
   output logic                             pll_rst,
   output logic [NUM_DOMAINS-1:0]           domain_rst,
   output logic                             ready,
   output logic                             fail,
   output logic [$clog2(MAX_RETRIES+1)-1:0] retry_count
);

   localparam int unsigned CNT_W = cnt_width(max_u(max_u(RST_CYCLES, LOCK_STABLE), STAGE_GAP));
   localparam int unsigned TMO_W = cnt_width(LOCK_TIMEOUT);
   localparam int unsigned STG_W = cnt_width(NUM_DOMAINS);
   localparam int unsigned RTY_W = $clog2(MAX_RETRIES + 1);

   localparam logic [CNT_W-1:0]       RST_LAST    = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0]       STABLE_DONE = CNT_W'(LOCK_STABLE);
   localparam logic [CNT_W-1:0]       GAP_LAST    = CNT_W'(STAGE_GAP - 1);
   localparam logic [TMO_W-1:0]       TMO_LAST    = TMO_W'(LOCK_TIMEOUT - 1);
   localparam logic [STG_W-1:0]       STG_LAST    = STG_W'(NUM_DOMAINS);
   localparam logic [STG_W-1:0]       STG_FIRST   = STG_W'(1);
   localparam logic [RTY_W-1:0]       RTY_MAX     = RTY_W'(MAX_RETRIES);
   localparam logic [NUM_DOMAINS-1:0] DOM_ALL     = '1;
   localparam logic [NUM_DOMAINS-1:0] DOM_FIRST   = DOM_ALL << 1;

   pll_seq_state_t         r_state;
   logic [CNT_W-1:0]       r_cnt;
   logic [TMO_W-1:0]       r_tmo;
   logic [STG_W-1:0]       r_stage;
   logic                   r_pll_rst;
   logic [NUM_DOMAINS-1:0] r_domain_rst;
   logic                   r_ready;
   logic                   r_fail;
   logic [RTY_W-1:0]       r_retry;

   logic                   w_locked_s;
   logic                   w_timeout;
   logic [RTY_W-1:0]       w_retry_inc;

   sync_2ff u_lock_sync (
      .i_clk   (refclk),
      .i_rst_n (rst_n),
      .i_d     (pll_locked),
      .o_q     (w_locked_s)
   );

   assign w_timeout   = (r_tmo == TMO_LAST);
   assign w_retry_inc = r_retry + 1'b1;

   // Priority: reset, restart, lock timeout, lock loss, then normal sequencing.
   always_ff @(posedge refclk) begin
      if (!rst_n) begin
         r_state      <= PLL_RST;
         r_cnt        <= '0;
         r_tmo        <= '0;
         r_stage      <= '0;
         r_pll_rst    <= 1'b1;
         r_domain_rst <= DOM_ALL;
         r_ready      <= 1'b0;
         r_fail       <= 1'b0;
         r_retry      <= '0;
      end else if (restart) begin
         r_state      <= PLL_RST;
         r_cnt        <= '0;
         r_tmo        <= '0;
         r_stage      <= '0;
         r_pll_rst    <= 1'b1;
         r_domain_rst <= DOM_ALL;
         r_ready      <= 1'b0;
         r_fail       <= 1'b0;
         r_retry      <= '0;
      end else if ((r_state == WAIT_LOCK || r_state == STABLE) && w_timeout) begin
         r_retry   <= w_retry_inc;
         r_cnt     <= '0;
         r_tmo     <= '0;
         r_pll_rst <= 1'b1;
         if (w_retry_inc == RTY_MAX) begin
            r_state <= FAIL;
            r_fail  <= 1'b1;
         end else begin
            r_state <= PLL_RST;
         end
      end else if ((r_state == RELEASE || r_state == RUN) && !w_locked_s) begin
         r_state      <= PLL_RST;
         r_cnt        <= '0;
         r_pll_rst    <= 1'b1;
         r_domain_rst <= DOM_ALL;
         r_ready      <= 1'b0;
      end else begin
         case (r_state)
            PLL_RST: begin
               r_tmo <= '0;
               if (r_cnt == RST_LAST) begin
                  r_cnt     <= '0;
                  r_pll_rst <= 1'b0;
                  r_state   <= WAIT_LOCK;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            WAIT_LOCK: begin
               r_tmo <= r_tmo + 1'b1;
               if (w_locked_s) begin
                  r_state <= STABLE;
                  r_cnt   <= '0;
               end
            end
            STABLE: begin
               r_tmo <= r_tmo + 1'b1;
               if (!w_locked_s) begin
                  r_state <= WAIT_LOCK;
               end else if (r_cnt == STABLE_DONE) begin
                  r_state      <= RELEASE;
                  r_cnt        <= '0;
                  r_stage      <= STG_FIRST;
                  r_domain_rst <= DOM_FIRST;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            RELEASE: begin
               // Shifting zeros in from bit 0 keeps the release order fixed.
               if (r_cnt == GAP_LAST) begin
                  r_cnt <= '0;
                  if (r_stage == STG_LAST) begin
                     r_state <= RUN;
                     r_ready <= 1'b1;
                     r_retry <= '0;
                  end else begin
                     r_domain_rst <= r_domain_rst << 1;
                     r_stage      <= r_stage + 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            RUN, FAIL: begin
               r_state <= r_state;
            end
            default: begin
               r_state      <= PLL_RST;
               r_pll_rst    <= 1'b1;
               r_domain_rst <= DOM_ALL;
               r_ready      <= 1'b0;
            end
         endcase
      end
   end

   assign pll_rst     = r_pll_rst;
   assign domain_rst  = r_domain_rst;
   assign ready       = r_ready;
   assign fail        = r_fail;
   assign retry_count = r_retry;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed scoreboard bench for pll_reset_sequencer: each change of the output
// vector is matched against the next hand-computed (cycle, value) expectation.
`timescale 1ns/1ps
module tb_pll_reset_sequencer;

   logic       refclk = 1'b0;
   logic       rst_n;
   logic       pll_locked;
   logic       restart;
   logic       pll_rst;
   logic [3:0] domain_rst;
   logic       ready;
   logic       fail;
   logic [1:0] retry_count;

   typedef struct {
      int         cyc;
      logic [8:0] val;
      string      name;
   } exp_t;

   exp_t       expQ[$];
   int         cyc = 0;
   int         vectors = 0;
   int         miscompares = 0;
   logic [8:0] prevSnap = 'x;
   logic [8:0] monSnap;

   pll_reset_sequencer #(
      .RST_CYCLES   (4),
      .LOCK_STABLE  (8),
      .LOCK_TIMEOUT (32),
      .STAGE_GAP    (2),
      .NUM_DOMAINS  (4),
      .MAX_RETRIES  (2)
   ) dut (
      .refclk      (refclk),
      .rst_n       (rst_n),
      .pll_locked  (pll_locked),
      .restart     (restart),
      .pll_rst     (pll_rst),
      .domain_rst  (domain_rst),
      .ready       (ready),
      .fail        (fail),
      .retry_count (retry_count)
   );

   always #5 refclk = ~refclk;

   always @(posedge refclk) cyc <= cyc + 1;

   // Output vector layout: {pll_rst, fail, ready, retry_count[1:0], domain_rst[3:0]}
   function automatic logic [8:0] vec(input bit pr, input bit fl, input bit rd,
                                      input bit [1:0] rc, input bit [3:0] dr);
      return {pr, fl, rd, rc, dr};
   endfunction

   task automatic pushExp(input int c, input logic [8:0] v, input string n);
      exp_t e;
      e.cyc  = c;
      e.val  = v;
      e.name = n;
      expQ.push_back(e);
   endtask

   task automatic applyStimulus(input logic r, input logic l, input logic s);
      rst_n      = r;
      pll_locked = l;
      restart    = s;
   endtask

   task automatic waitTo(input int n);
      while (cyc < n) @(negedge refclk);
   endtask

   task automatic checkOutput(input logic [8:0] snap);
      exp_t e;
      vectors++;
      if (expQ.size() == 0) begin
         miscompares++;
         $display("[TB] FAIL unexpected-change: got %b at cyc %0d, no change expected", snap, cyc);
      end else begin
         e = expQ.pop_front();
         if (snap !== e.val || cyc != e.cyc) begin
            miscompares++;
            $display("[TB] FAIL %s: got %b at cyc %0d, expected %b at cyc %0d",
                     e.name, snap, cyc, e.val, e.cyc);
         end
      end
   endtask

   // Monitor: any change of the registered outputs consumes one expectation.
   always @(negedge refclk) begin
      monSnap = {pll_rst, fail, ready, retry_count, domain_rst};
      if (monSnap !== prevSnap) begin
         checkOutput(monSnap);
         prevSnap = monSnap;
      end
   end

   initial begin
      applyStimulus(1'b0, 1'b0, 1'b0);

      // Reset values, then pll_rst held for 4 edges after rst_n rises
      pushExp(1, vec(1, 0, 0, 2'd0, 4'b1111), "reset-values");
      pushExp(7, vec(0, 0, 0, 2'd0, 4'b1111), "pll-rst-fall");
      pushExp(21, vec(0, 0, 0, 2'd0, 4'b1110), "bringup-dom0");
      pushExp(23, vec(0, 0, 0, 2'd0, 4'b1100), "bringup-dom1");
      pushExp(25, vec(0, 0, 0, 2'd0, 4'b1000), "bringup-dom2");
      pushExp(27, vec(0, 0, 0, 2'd0, 4'b0000), "bringup-dom3");
      pushExp(29, vec(0, 0, 1, 2'd0, 4'b0000), "bringup-ready");
      waitTo(3);
      applyStimulus(1'b1, 1'b0, 1'b0);
      waitTo(9);
      applyStimulus(1'b1, 1'b1, 1'b0);

      // Lock lost in RUN: everything collapses, retry_count untouched
      pushExp(35, vec(1, 0, 0, 2'd0, 4'b1111), "run-lockloss");
      pushExp(39, vec(0, 0, 0, 2'd0, 4'b1111), "relock-pll-fall");
      waitTo(32);
      applyStimulus(1'b1, 1'b0, 1'b0);

      // One-cycle lock glitch at stable count 5 restarts the debounce
      pushExp(58, vec(0, 0, 0, 2'd0, 4'b1110), "glitch-dom0");
      pushExp(60, vec(0, 0, 0, 2'd0, 4'b1100), "glitch-dom1");
      pushExp(62, vec(0, 0, 0, 2'd0, 4'b1000), "glitch-dom2");
      pushExp(64, vec(0, 0, 0, 2'd0, 4'b0000), "glitch-dom3");
      pushExp(66, vec(0, 0, 1, 2'd0, 4'b0000), "glitch-ready");
      waitTo(39);
      applyStimulus(1'b1, 1'b1, 1'b0);
      waitTo(45);
      applyStimulus(1'b1, 1'b0, 1'b0);
      waitTo(46);
      applyStimulus(1'b1, 1'b1, 1'b0);

      // Lock held low: two timeouts, second one lands in FAIL
      pushExp(71, vec(1, 0, 0, 2'd0, 4'b1111), "held-low-collapse");
      pushExp(75, vec(0, 0, 0, 2'd0, 4'b1111), "held-low-fall1");
      pushExp(107, vec(1, 0, 0, 2'd1, 4'b1111), "timeout1-retry1");
      pushExp(111, vec(0, 0, 0, 2'd1, 4'b1111), "held-low-fall2");
      pushExp(143, vec(1, 1, 0, 2'd2, 4'b1111), "timeout2-fail");
      waitTo(68);
      applyStimulus(1'b1, 1'b0, 1'b0);

      // Restart out of FAIL with lock already present
      pushExp(151, vec(1, 0, 0, 2'd0, 4'b1111), "restart-from-fail");
      pushExp(155, vec(0, 0, 0, 2'd0, 4'b1111), "restart-pll-fall");
      pushExp(165, vec(0, 0, 0, 2'd0, 4'b1110), "restart-dom0");
      pushExp(167, vec(0, 0, 0, 2'd0, 4'b1100), "restart-dom1");
      pushExp(169, vec(0, 0, 0, 2'd0, 4'b1000), "restart-dom2");
      pushExp(171, vec(0, 0, 0, 2'd0, 4'b0000), "restart-dom3");
      pushExp(173, vec(0, 0, 1, 2'd0, 4'b0000), "restart-ready");
      waitTo(146);
      applyStimulus(1'b1, 1'b1, 1'b0);
      waitTo(150);
      applyStimulus(1'b1, 1'b1, 1'b1);
      waitTo(151);
      applyStimulus(1'b1, 1'b1, 1'b0);

      // Restart on the very edge the lock timeout fires
      pushExp(178, vec(1, 0, 0, 2'd0, 4'b1111), "tmo-run-collapse");
      pushExp(182, vec(0, 0, 0, 2'd0, 4'b1111), "tmo-pll-fall");
      pushExp(214, vec(1, 0, 0, 2'd0, 4'b1111), "restart-beats-timeout");
      pushExp(218, vec(0, 0, 0, 2'd0, 4'b1111), "post-restart-fall");
      waitTo(175);
      applyStimulus(1'b1, 1'b0, 1'b0);
      waitTo(213);
      applyStimulus(1'b1, 1'b0, 1'b1);
      waitTo(214);
      applyStimulus(1'b1, 1'b0, 1'b0);

      // rst_n asserted mid-RELEASE, then a full bring-up with lock continuously high
      pushExp(231, vec(0, 0, 0, 2'd0, 4'b1110), "midrel-dom0");
      pushExp(233, vec(0, 0, 0, 2'd0, 4'b1100), "midrel-dom1");
      pushExp(234, vec(1, 0, 0, 2'd0, 4'b1111), "midrel-reset-values");
      pushExp(240, vec(0, 0, 0, 2'd0, 4'b1111), "rerun-pll-fall");
      pushExp(250, vec(0, 0, 0, 2'd0, 4'b1110), "rerun-dom0");
      pushExp(252, vec(0, 0, 0, 2'd0, 4'b1100), "rerun-dom1");
      pushExp(254, vec(0, 0, 0, 2'd0, 4'b1000), "rerun-dom2");
      pushExp(256, vec(0, 0, 0, 2'd0, 4'b0000), "rerun-dom3");
      pushExp(258, vec(0, 0, 1, 2'd0, 4'b0000), "rerun-ready");
      waitTo(219);
      applyStimulus(1'b1, 1'b1, 1'b0);
      waitTo(233);
      applyStimulus(1'b0, 1'b1, 1'b0);
      waitTo(236);
      applyStimulus(1'b1, 1'b1, 1'b0);

      waitTo(264);
      while (expQ.size() != 0) begin
         exp_t e;
         e = expQ.pop_front();
         vectors++;
         miscompares++;
         $display("[TB] FAIL %s: output never changed, expected %b at cyc %0d", e.name, e.val, e.cyc);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
